regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Multi-port register file, parametrised in data width, depth, and read/write port count.
//   Storage is a flop array. Each read port is a registered read with write-to-read bypass.
//   Write-port collisions are resolved deterministically and reported on a one-cycle flag.
//   Sits in the datapath between decode (addresses) and execute (operands); replaces fixed 32:1 read muxing.
// PARAMETERS
//   WIDTH    32  data bits per register
//   DEPTH    32  number of registers (2..2**ADDR_W)
//   ADDR_W   5   address bits per port
//   N_RD     2   number of read ports (1..4)
//   N_WR     2   number of write ports (1..4)
//   ZERO_R0  1   1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//   clk        in   1              rising-edge clock
//   rst        in   1              asynchronous active-high reset
//   rd_en      in   N_RD           per-port read enable
//   rd_addr    in   N_RD*ADDR_W    port i address at [i*ADDR_W +: ADDR_W]
//   rd_data    out  N_RD*WIDTH     port i data at [i*WIDTH +: WIDTH], registered
//   rd_valid   out  N_RD           port i: rd_data updated this cycle (rd_en delayed 1 clk)
//   wr_en      in   N_WR           per-port write enable
//   wr_addr    in   N_WR*ADDR_W    port j address at [j*ADDR_W +: ADDR_W]
//   wr_data    in   N_WR*WIDTH     port j data at [j*WIDTH +: WIDTH]
//   wr_conflict out 1              registered; 1 for one cycle after >=2 enabled writes hit same valid addr
// BEHAVIOUR
//   Reset (rst=1, async): all DEPTH registers, rd_data, rd_valid, and wr_conflict clear to 0 immediately.
//   Clock: operation is held while rst=1.
//   Write: at posedge, for each j with wr_en[j]=1, mem[wr_addr_j] <= wr_data_j.
//   Write collision: if several ports target the same address, the highest-index port wins.
//     wr_conflict <= 1 on that edge, else 0.
//     Disabled ports never count toward a collision.
//   Invalid addresses: a write with wr_addr >= DEPTH is dropped, with no conflict and no side effect.
//     A read with rd_addr >= DEPTH returns 0.
//   ZERO_R0=1: writes to address 0 are dropped and do not raise wr_conflict; reads of address 0 return 0.
//   Read latency is 1 clk.
//     If rd_en[i]=1 at edge k, rd_data_i holds the value from edge k until the next enabled read on port i.
//     rd_valid[i]=1 during cycle k+1 only.
//     If rd_en[i]=0, rd_data_i holds its previous value.
//   Bypass (write-first): if an enabled write at edge k hits the same valid address as read port i,
//     rd_data_i shows the new data after edge k.
//     When several writes hit that address, the winner is the highest-index port (same rule as storage).
//   Read ports are fully independent. Any number of them may read the same address in one cycle.
//   Width rules: data is stored unmodified with no sign extension. Unused address space above DEPTH is not allocated.
//   No internal FSM beyond storage, rd_valid, and conflict flops. All outputs come directly from flops (no comb path from inputs).
// TESTING
//   1 Reset: write 0xDEAD_BEEF to r5, assert rst mid-cycle -> r5, rd_data, rd_valid, and wr_conflict are 0 before the next edge.
//   2 Basic: wr0 r7=0x1234_5678; next cycle rd0 r7 -> rd_data0=0x1234_5678 and rd_valid[0]=1 one clk after rd_en.
//   3 Bypass: same edge wr1 r9=0xA5A5_A5A5 and rd0/rd1 r9 -> both ports read 0xA5A5_A5A5 after that edge (not the old value).
//   4 Collision: wr0 r3=0x1111 and wr1 r3=0x2222 on the same edge -> r3=0x2222 and wr_conflict=1 for exactly 1 cycle.
//     Repeat with wr_en=2'b01 -> wr_conflict stays 0.
//   5 Zero/out-of-range: ZERO_R0=1, write r0=0xFFFF_FFFF -> read r0=0 with no conflict.
//     DEPTH=24, write r30 -> dropped; read r30 -> 0.
//   6 Hold/param sweep: rd_en=0 with address change -> rd_data is unchanged.
//     Rerun tests 2-4 with WIDTH=16, DEPTH=8, ADDR_W=3, N_RD=4, N_WR=3.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port flop register file: write-first bypass, highest-index write port wins a collision.
// Registered 1-clk reads; no backpressure, every enabled access is accepted on the edge.
module regfile_mp #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int N_RD    = 2,
    parameter int N_WR    = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_RD-1:0]        rd_en,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*WIDTH-1:0]  rd_data,
    output logic [N_RD-1:0]        rd_valid,
    input  logic [N_WR-1:0]        wr_en,
    input  logic [N_WR*ADDR_W-1:0] wr_addr,
    input  logic [N_WR*WIDTH-1:0]  wr_data,
    output logic                   wr_conflict
);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [N_RD*WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [N_RD-1:0]        rd_valid_q, rd_valid_d;
    logic                   wr_conflict_q, wr_conflict_d;
    logic [ADDR_W-1:0]      wa [N_WR];
    logic [ADDR_W-1:0]      ra [N_RD];

    // Out-of-range addresses and (optionally) r0 are never stored to and always read as zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    always_comb begin : unpack
        for (int j = 0; j < N_WR; j++) wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
        for (int i = 0; i < N_RD; i++) ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
    end

    always_comb begin : write_path
        mem_d         = mem_q;
        wr_conflict_d = 1'b0;
        // Later ports overwrite earlier ones, so the highest enabled index wins.
        for (int a = 0; a < DEPTH; a++) begin
            for (int j = 0; j < N_WR; j++) begin
                if (wr_en[j] && addr_ok(wa[j]) && (wa[j] == ADDR_W'(a))) begin
                    mem_d[a] = wr_data[j*WIDTH +: WIDTH];
                end
            end
        end
        for (int j = 0; j < N_WR; j++) begin
            for (int k = j + 1; k < N_WR; k++) begin
                if (wr_en[j] && wr_en[k] && addr_ok(wa[j]) && (wa[j] == wa[k])) begin
                    wr_conflict_d = 1'b1;
                end
            end
        end
    end

    // Reading from mem_d gives write-first bypass for free.
    always_comb begin : read_path
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        for (int i = 0; i < N_RD; i++) begin
            if (rd_en[i]) begin
                rd_data_d[i*WIDTH +: WIDTH] = '0;
                for (int a = 0; a < DEPTH; a++) begin
                    if (addr_ok(ra[i]) && (ra[i] == ADDR_W'(a))) begin
                        rd_data_d[i*WIDTH +: WIDTH] = mem_d[a];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) mem_q[a] <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance checked every cycle against a behavioural model,
// plus directed checks on a DEPTH=24 instance and a 16-bit/8-deep/4R3W instance.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // default configuration
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_conflict;

    // DEPTH=24, one read port
    logic        d_rd_en;
    logic [4:0]  d_rd_addr;
    logic [31:0] d_rd_data;
    logic        d_rd_valid;
    logic [1:0]  d_wr_en;
    logic [9:0]  d_wr_addr;
    logic [63:0] d_wr_data;
    logic        d_wr_conflict;

    // WIDTH=16, DEPTH=8, ADDR_W=3, N_RD=4, N_WR=3
    logic [3:0]  s_rd_en;
    logic [11:0] s_rd_addr;
    logic [63:0] s_rd_data;
    logic [3:0]  s_rd_valid;
    logic [2:0]  s_wr_en;
    logic [8:0]  s_wr_addr;
    logic [47:0] s_wr_data;
    logic        s_wr_conflict;

    regfile_mp u_dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_conflict(wr_conflict)
    );

    regfile_mp #(.DEPTH(24), .N_RD(1)) u_d24 (
        .clk(clk), .rst(rst),
        .rd_en(d_rd_en), .rd_addr(d_rd_addr), .rd_data(d_rd_data), .rd_valid(d_rd_valid),
        .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data), .wr_conflict(d_wr_conflict)
    );

    regfile_mp #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .N_RD(4), .N_WR(3)) u_sw (
        .clk(clk), .rst(rst),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_conflict(s_wr_conflict)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of the default instance: an array of registers updated per edge.
    logic [31:0] m_mem [32];
    int          m_hits [32];
    logic [31:0] m_rd [2];
    logic [1:0]  m_vld;
    logic        m_conf;
    logic [4:0]  m_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) m_mem[a] = '0;
            m_rd[0] = '0;
            m_rd[1] = '0;
            m_vld   = '0;
            m_conf  = 1'b0;
        end else begin
            m_conf = 1'b0;
            for (int a = 0; a < 32; a++) m_hits[a] = 0;
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j]) begin
                    m_a = wr_addr[j*5 +: 5];
                    if (m_a != 5'd0) begin
                        m_mem[m_a] = wr_data[j*32 +: 32];
                        m_hits[m_a]++;
                        if (m_hits[m_a] > 1) m_conf = 1'b1;
                    end
                end
            end
            m_vld = rd_en;
            for (int i = 0; i < 2; i++) begin
                if (rd_en[i]) begin
                    m_a = rd_addr[i*5 +: 5];
                    m_rd[i] = (m_a == 5'd0) ? 32'd0 : m_mem[m_a];
                end
            end
        end
        #1;
        chk("model_rd_data0", {32'd0, rd_data[31:0]}, {32'd0, m_rd[0]});
        chk("model_rd_data1", {32'd0, rd_data[63:32]}, {32'd0, m_rd[1]});
        chk("model_rd_valid", {62'd0, rd_valid}, {62'd0, m_vld});
        chk("model_wr_conflict", {63'd0, wr_conflict}, {63'd0, m_conf});
    end

    task automatic tick();
        @(posedge clk);
        #2;
        rd_en   = '0;
        wr_en   = '0;
        d_rd_en = '0;
        d_wr_en = '0;
        s_rd_en = '0;
        s_wr_en = '0;
    endtask

    initial begin
        rst = 1'b1;
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        d_rd_en = '0; d_rd_addr = '0; d_wr_en = '0; d_wr_addr = '0; d_wr_data = '0;
        s_rd_en = '0; s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rd_data", rd_data, 64'd0);
        chk("reset_rd_valid", {62'd0, rd_valid}, 64'd0);
        chk("reset_conflict", {63'd0, wr_conflict}, 64'd0);
        chk("reset_s_rd_data", s_rd_data, 64'd0);
        rst = 1'b0;

        // asynchronous reset mid-cycle
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEAD_BEEF; tick();
        rd_en = 2'b01; rd_addr[4:0] = 5'd5; tick();
        chk("r5_before_rst", {32'd0, rd_data[31:0]}, 64'h0000_0000_DEAD_BEEF);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_rd_data", rd_data, 64'd0);
        chk("rst_mid_rd_valid", {62'd0, rd_valid}, 64'd0);
        chk("rst_mid_conflict", {63'd0, wr_conflict}, 64'd0);
        #2 rst = 1'b0;
        rd_en = 2'b01; rd_addr[4:0] = 5'd5; tick();
        chk("r5_after_rst", {32'd0, rd_data[31:0]}, 64'd0);
        chk("r5_after_rst_vld", {62'd0, rd_valid}, 64'd1);

        // basic write then read
        wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[31:0] = 32'h1234_5678; tick();
        rd_en = 2'b01; rd_addr[4:0] = 5'd7; tick();
        chk("basic_rd_data0", {32'd0, rd_data[31:0]}, 64'h1234_5678);
        chk("basic_rd_valid", {62'd0, rd_valid}, 64'd1);
        tick();
        chk("basic_valid_drop", {62'd0, rd_valid}, 64'd0);
        chk("basic_data_held", {32'd0, rd_data[31:0]}, 64'h1234_5678);

        // write-first bypass on both read ports
        wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h0000_0BAD; tick();
        wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'hA5A5_A5A5;
        rd_en = 2'b11; rd_addr = {5'd9, 5'd9}; tick();
        chk("bypass_both", rd_data, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("bypass_valid", {62'd0, rd_valid}, 64'd3);

        // collision: highest port wins, flag pulses one cycle
        wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h2222, 32'h1111}; tick();
        chk("collide_flag", {63'd0, wr_conflict}, 64'd1);
        rd_en = 2'b01; rd_addr[4:0] = 5'd3; tick();
        chk("collide_flag_clear", {63'd0, wr_conflict}, 64'd0);
        chk("collide_winner", {32'd0, rd_data[31:0]}, 64'h2222);
        wr_en = 2'b01; wr_addr = {5'd3, 5'd3}; wr_data = {32'h2222, 32'h1111}; tick();
        chk("single_no_flag", {63'd0, wr_conflict}, 64'd0);
        rd_en = 2'b10; rd_addr[9:5] = 5'd3; tick();
        chk("single_value", {32'd0, rd_data[63:32]}, 64'h1111);

        // r0 hardwired to zero, even with a same-edge double write
        wr_en = 2'b11; wr_addr = '0; wr_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        rd_en = 2'b01; rd_addr[4:0] = 5'd0; tick();
        chk("r0_no_conflict", {63'd0, wr_conflict}, 64'd0);
        chk("r0_reads_zero", {32'd0, rd_data[31:0]}, 64'd0);

        // hold when read disabled and address moves
        rd_en = 2'b01; rd_addr[4:0] = 5'd7; tick();
        chk("hold_setup", {32'd0, rd_data[31:0]}, 64'h1234_5678);
        rd_addr[4:0] = 5'd9; tick();
        chk("hold_data", {32'd0, rd_data[31:0]}, 64'h1234_5678);
        chk("hold_valid", {62'd0, rd_valid}, 64'd0);

        // DEPTH=24: top valid register and out-of-range address
        d_wr_en = 2'b01; d_wr_addr[4:0] = 5'd23; d_wr_data[31:0] = 32'h55; tick();
        d_rd_en = 1'b1; d_rd_addr = 5'd23; tick();
        chk("d24_r23", {32'd0, d_rd_data}, 64'h55);
        d_wr_en = 2'b11; d_wr_addr = {5'd30, 5'd30}; d_wr_data = {32'h66, 32'h77}; tick();
        chk("d24_oob_no_conflict", {63'd0, d_wr_conflict}, 64'd0);
        d_rd_en = 1'b1; d_rd_addr = 5'd30; tick();
        chk("d24_oob_read_zero", {32'd0, d_rd_data}, 64'd0);
        chk("d24_oob_valid", {63'd0, d_rd_valid}, 64'd1);
        d_wr_en = 2'b11; d_wr_addr = {5'd23, 5'd23}; d_wr_data = {32'h99, 32'h88}; tick();
        chk("d24_collide_flag", {63'd0, d_wr_conflict}, 64'd1);
        d_rd_en = 1'b1; d_rd_addr = 5'd23; tick();
        chk("d24_collide_winner", {32'd0, d_rd_data}, 64'h99);
        d_rd_en = 1'b1; d_rd_addr = 5'd6; tick();
        chk("d24_no_alias_r6", {32'd0, d_rd_data}, 64'd0);

        // parameter sweep: 16-bit, 8 deep, 4 read / 3 write ports
        s_wr_en = 3'b001; s_wr_addr[2:0] = 3'd7; s_wr_data[15:0] = 16'h1234; tick();
        s_rd_en = 4'b0001; s_rd_addr[2:0] = 3'd7; tick();
        chk("sw_basic", {48'd0, s_rd_data[15:0]}, 64'h1234);
        chk("sw_basic_valid", {60'd0, s_rd_valid}, 64'h1);
        s_wr_en = 3'b101; s_wr_addr = {3'd5, 3'd0, 3'd5}; s_wr_data = {16'hA5A5, 16'h0000, 16'h1111};
        s_rd_en = 4'b1110; s_rd_addr = {3'd5, 3'd5, 3'd5, 3'd0}; tick();
        chk("sw_bypass", {16'd0, s_rd_data[63:16]}, 64'h0000_A5A5_A5A5_A5A5);
        chk("sw_bypass_conflict", {63'd0, s_wr_conflict}, 64'd1);
        chk("sw_bypass_valid", {60'd0, s_rd_valid}, 64'hE);
        s_wr_en = 3'b011; s_wr_addr = {3'd0, 3'd3, 3'd3}; s_wr_data = {16'h0000, 16'h2222, 16'h1111}; tick();
        chk("sw_collide_flag", {63'd0, s_wr_conflict}, 64'd1);
        s_rd_en = 4'b1000; s_rd_addr[11:9] = 3'd3; tick();
        chk("sw_collide_clear", {63'd0, s_wr_conflict}, 64'd0);
        chk("sw_collide_winner", {48'd0, s_rd_data[63:48]}, 64'h2222);
        chk("sw_port0_held", {48'd0, s_rd_data[15:0]}, 64'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
